imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Upstream of the single-cycle MIPS core. Receives a program as a byte stream over a valid/ready handshake and writes it word-by-word into instruction memory through a dedicated write port.
- Holds the core in reset (`cpu_reset`) until the whole image is loaded and its checksum passes. It then releases the core to fetch from `BASE_ADDR`.
- Flags a bad image and keeps the core parked.

Parameters:
- `MAX_WORDS`, 256: largest accepted image in 32-bit words; the word index counter is sized from this.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word written; must match the PC reset value.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `rx_valid` input 1: a byte is offered on `rx_data`.
- `rx_data` input 8: stream byte.
- `rx_ready` output 1: loader can accept a byte this cycle.
- `imem_we` output 1: instruction-memory write strobe, one cycle per word.
- `imem_addr` output 32: byte address for the write, word-aligned.
- `imem_wdata` output 32: instruction word to write.
- `cpu_reset` output 1: reset to the core; 1 = core held.
- `done` output 1: image loaded and verified; core running.
- `error` output 1: image rejected (length or checksum).

Behaviour:
- Stream format, in order:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - 4·N payload bytes: each word big-endian, MSB first.
  - 1 checksum byte: XOR of every preceding byte, length bytes included.
- Transfer rule: a byte is accepted only on a rising edge with `rx_valid` && `rx_ready`. `rx_data` is ignored otherwise; gaps in `rx_valid` of any length are legal.
- States: `S_LEN_HI`, `S_LEN_LO`, `S_DATA`, `S_CHECK`, `S_RUN`, `S_ERROR`.
- `rx_ready` = 1 in `S_LEN_HI`, `S_LEN_LO`, `S_DATA` and `S_CHECK`; 0 in `S_RUN` and `S_ERROR`. It is forced to 0 while `reset` = 1.
- State transitions, each on an accepted byte unless stated:
  - `S_LEN_HI` → `S_LEN_LO`.
  - `S_LEN_LO`:
    - N > `MAX_WORDS` → `S_ERROR`.
    - N == 0 → `S_CHECK`.
    - Otherwise → `S_DATA`.
  - `S_DATA`: the byte counter cycles 0..3. On the 4th byte:
    - Register `imem_wdata` = {shift_buf[23:0], `rx_data`}.
    - Register `imem_addr` = `BASE_ADDR` + 4·idx.
    - Pulse `imem_we` = 1 for exactly the next cycle.
    - Increment idx.
    - When idx reaches N → `S_CHECK`.
  - `S_CHECK`: the received byte is compared to the running XOR.
    - Equal → `S_RUN`.
    - Not equal → `S_ERROR`.
  - `S_RUN` and `S_ERROR` are terminal; only `reset` leaves them.
- Write latency: `imem_we` is high in the cycle after the 4th byte is accepted, with addr and data stable in that cycle. `rx_ready` stays high during the write, and the next byte may be accepted in that same cycle.
- Running checksum: 8-bit XOR register, cleared on reset, updated on every accepted byte before `S_CHECK`.
- Outputs:
  - `S_RUN`: `cpu_reset` = 0, `done` = 1.
  - `S_ERROR`: `cpu_reset` = 1, `error` = 1.
  - All other states: `cpu_reset` = 1, `done` = 0, `error` = 0.
  - All three outputs are registered and change on the edge that enters the state.
- Reset values: `imem_we` = 0, `imem_addr` = `BASE_ADDR`, `imem_wdata` = 0, `cpu_reset` = 1, `done` = 0, `error` = 0. State = `S_LEN_HI`; idx, byte counter, shift_buf and checksum = 0.
- Reset mid-load: any cycle with `reset` = 1 aborts the load. The FSM and counters clear, and any pending `imem_we` is suppressed. Memory already written is not cleared, and the next image simply overwrites it.
- Address arithmetic is 32-bit unsigned with no wrap check. `MAX_WORDS` bounds idx.

Test Plan:
- Good 2-word image: bytes 00 02 20 08 00 05 AC 08 00 00 8B, `rx_valid` held high. Required response:
  - Two `imem_we` pulses: (addr 0x0, data 0x20080005), then (addr 0x4, data 0xAC080000).
  - One cycle after 8B is accepted: `cpu_reset` falls and `done` = 1.
  - `rx_ready` = 0 thereafter.
- Same image with checksum byte 8A → both writes occur; `error` = 1, `cpu_reset` stays 1, `done` = 0.
- Length 00 00 then checksum 00 → no `imem_we` pulse; `done` = 1, `cpu_reset` = 0.
- With `MAX_WORDS` = 256, length 01 01 (257) → `error` = 1 right after LEN_LO is accepted; `rx_ready` = 0; no writes.
- Good image with random 0–5 cycle `rx_valid` gaps, and one byte presented while `rx_ready` = 0 after done → writes and the done cycle are identical apart from the shift caused by the gaps; the extra byte is ignored.
- Assert `reset` for one cycle after the 6th byte of the good image, then resend the full image → no `imem_we` pulse for the aborted word; the second load completes with the same two writes and `done` = 1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream, writes it
// word-by-word into instruction memory and releases the core once the image verifies.
module imem_boot_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam int unsigned IW = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t         state;
    logic [15:0]    len;
    logic [IW-1:0]  idx;
    logic [1:0]     bcnt;
    logic [23:0]    shift_buf;
    logic [7:0]     csum;
    logic [15:0]    len_n;
    logic           accept;

    assign rx_ready = !reset && (state != S_RUN) && (state != S_ERROR);
    assign accept   = rx_valid && rx_ready;
    assign len_n    = {len[15:8], rx_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_LEN_HI;
            len        <= '0;
            idx        <= '0;
            bcnt       <= '0;
            shift_buf  <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
                if (state != S_CHECK) begin
                    csum <= csum ^ rx_data;
                end
                case (state)
                    S_LEN_HI: begin
                        len   <= {rx_data, 8'h00};
                        state <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        len <= len_n;
                        if (32'(len_n) > MAX_WORDS) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end else if (len_n == 16'd0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        shift_buf <= {shift_buf[15:0], rx_data};
                        bcnt      <= bcnt + 2'd1;
                        // Fourth byte completes a word: write it out next cycle.
                        if (bcnt == 2'd3) begin
                            imem_wdata <= {shift_buf[23:0], rx_data};
                            imem_addr  <= BASE_ADDR + (32'(idx) << 2);
                            imem_we    <= 1'b1;
                            idx        <= idx + IW'(1);
                            if (32'(idx) + 32'd1 == 32'(len)) begin
                                state <= S_CHECK;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (rx_data == csum) begin
                            state     <= S_RUN;
                            cpu_reset <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: a stream-level model predicts the writes,
// their timing relative to accepted bytes, and the final verdict of each image.
module tb_imem_boot_loader;

    localparam int MAXW = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready, imem_we, cpu_reset, done, error;
    logic [31:0] imem_addr, imem_wdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    imem_boot_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Observed write pulses and status rise times (cycle = posedge count).
    int mon_addr[$], mon_data[$], mon_cyc[$];
    int done_cyc = -1, err_cyc = -1;

    always @(negedge clk) begin
        if (imem_we) begin
            mon_addr.push_back(int'(imem_addr));
            mon_data.push_back(int'(imem_wdata));
            mon_cyc.push_back(cyc);
        end
        if (done && done_cyc < 0) done_cyc = cyc;
        if (error && err_cyc < 0) err_cyc = cyc;
    end

    // Stream and reference-model results.
    logic [7:0] img[$];
    int acc[$];
    int exp_addr[$], exp_data[$], exp_bi[$];
    int exp_final;  // 1 = run, 2 = error
    int exp_fi;     // index of the byte that ends the load

    task automatic model();
        int n;
        logic [7:0] x;
        exp_addr = {}; exp_data = {}; exp_bi = {};
        n = int'({img[0], img[1]});
        if (n > MAXW) begin
            exp_final = 2;
            exp_fi = 1;
            return;
        end
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(4 * w);
            exp_data.push_back(int'({img[2+4*w], img[3+4*w], img[4+4*w], img[5+4*w]}));
            exp_bi.push_back(5 + 4 * w);
        end
        x = 8'h00;
        for (int i = 0; i < 2 + 4 * n; i++) x = x ^ img[i];
        exp_fi = 2 + 4 * n;
        exp_final = (img[exp_fi] == x) ? 1 : 2;
    endtask

    task automatic build(input int n, input bit corrupt);
        logic [7:0] x, b;
        img = {};
        img.push_back(8'(n >> 8));
        img.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            img.push_back(b);
        end
        x = 8'h00;
        foreach (img[i]) x = x ^ img[i];
        if (corrupt) x = x ^ 8'(1 + $urandom_range(254, 0));
        img.push_back(x);
    endtask

    // Offer bytes 0..nbytes-1 with random idle gaps; record accept posedge of each.
    task automatic send(input int nbytes, input int gap_max);
        bit ok;
        acc = {};
        for (int i = 0; i < nbytes; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            if (g > 0) begin
                rx_valid = 1'b0;
                repeat (g) begin
                    rx_data = 8'($urandom);
                    @(negedge clk);
                end
            end
            rx_valid = 1'b1;
            rx_data  = img[i];
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                #1;
                if (rx_ready) begin
                    acc.push_back(cyc + 1);
                    ok = 1'b1;
                end
                @(negedge clk);
            end
            if (!ok) begin
                check("accept_timeout", 32'(rx_ready), 32'd1);
                acc.push_back(-1);
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rx_valid = 1'b0;
        #1;
        check("ready_in_reset", 32'(rx_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_ready", 32'(rx_ready), 32'd1);
    endtask

    task automatic run_image(input int gap_max);
        int nw;
        model();
        mon_addr = {}; mon_data = {}; mon_cyc = {};
        done_cyc = -1; err_cyc = -1;
        send(exp_fi + 1, gap_max);
        repeat (3) @(negedge clk);
        check("write_count", mon_addr.size(), exp_addr.size());
        nw = (mon_addr.size() < exp_addr.size()) ? mon_addr.size() : exp_addr.size();
        for (int k = 0; k < nw; k++) begin
            check("write_addr", mon_addr[k], exp_addr[k]);
            check("write_data", mon_data[k], exp_data[k]);
            check("write_cycle", mon_cyc[k], acc[exp_bi[k]]);
        end
        check("done", 32'(done), (exp_final == 1) ? 32'd1 : 32'd0);
        check("error", 32'(error), (exp_final == 2) ? 32'd1 : 32'd0);
        check("cpu_reset", 32'(cpu_reset), (exp_final == 1) ? 32'd0 : 32'd1);
        check("ready_after", 32'(rx_ready), 32'd0);
        if (exp_final == 1) check("done_cycle", done_cyc, acc[exp_fi]);
        else                check("error_cycle", err_cyc, acc[exp_fi]);
        // A byte offered after the terminal state must have no effect.
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        check("extra_no_write", mon_addr.size(), exp_addr.size());
        check("extra_done", 32'(done), (exp_final == 1) ? 32'd1 : 32'd0);
        check("extra_error", 32'(error), (exp_final == 2) ? 32'd1 : 32'd0);
    endtask

    task automatic load_good(input logic [7:0] cs);
        img = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00, cs};
    endtask

    initial begin
        int a4;
        do_reset();

        load_good(8'h8B);
        run_image(0);

        do_reset();
        load_good(8'h8A);
        run_image(0);

        do_reset();
        img = {8'h00, 8'h00, 8'h00};
        run_image(0);

        do_reset();
        img = {8'h01, 8'h01};
        run_image(0);

        do_reset();
        load_good(8'h8B);
        run_image(5);

        // Abort after the sixth byte, then reload from scratch.
        do_reset();
        load_good(8'h8B);
        mon_addr = {}; mon_data = {}; mon_cyc = {};
        send(6, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_we", 32'(imem_we), 32'd0);
        check("abort_ready", 32'(rx_ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        a4 = 0;
        foreach (mon_addr[k]) if (mon_addr[k] == 4) a4++;
        check("abort_no_word1", a4, 0);
        run_image(0);

        for (int it = 0; it < 20; it++) begin
            int n;
            do_reset();
            if ($urandom_range(5, 0) == 0) begin
                n = MAXW + 1 + int'($urandom_range(1000, 0));
                img = {8'(n >> 8), 8'(n)};
            end else begin
                n = int'($urandom_range(5, 0));
                build(n, $urandom_range(2, 0) == 0);
            end
            run_image(int'($urandom_range(3, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
